// File: rtl/mips_mem_pkg.sv
// Shared constants and types for the MIPS Harvard instruction-side memory.
package mips_mem_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } loader_state_t;

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x 32 instruction word store: synchronous write, asynchronous read.
// Latency: write visible to the read port the cycle after the write edge; no flow control.
module instr_mem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader + instruction memory: streams a program in (valid/ready, one word per cycle), then runs the CPU with
// zero-latency combinational fetch until it goes inactive. Optional sticky fetch error capture: INSTR_MEM_FETCH_ERR_EN.
module instr_mem_loader
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = RESET_VECTOR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [31:0]                load_data,
  input  logic                       load_last,
  output logic                       cpu_reset,
  output logic                       cpu_clk_enable,
  input  logic                       cpu_active,
  input  logic [31:0]                instr_address,
  output logic [31:0]                instr_readdata,
  output logic [$clog2(DEPTH):0]     loaded_words,
  output logic [1:0]                 run_state
`ifdef INSTR_MEM_FETCH_ERR_EN
  ,
  output logic                       fetch_err,
  output logic [31:0]                fetch_err_addr
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  loader_state_t state, state_nxt;
  logic [AW-1:0] wr_ptr;
  logic          seen_active;
  logic          load_accept;

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          hit;
  logic [31:0]   rd_data;
  logic          unused_off;

  assign load_accept = load_valid && load_ready;
  assign run_state   = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_ready     = 1'b0;
    cpu_reset      = 1'b0;
    cpu_clk_enable = 1'b0;
    case (state)
      LOAD: begin
        load_ready = 1'b1;
        cpu_reset  = 1'b1;
        // Leave on the final word, whether flagged by load_last or by filling the array.
        if (load_valid && (load_last || loaded_words == LAST_CNT)) state_nxt = RUN;
      end
      RUN: begin
        cpu_clk_enable = 1'b1;
        if (seen_active && !cpu_active) state_nxt = HALTED;
      end
      HALTED: ;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      loaded_words <= '0;
      seen_active  <= 1'b0;
    end else begin
      if (load_accept) begin
        wr_ptr       <= wr_ptr + AW'(1);
        loaded_words <= loaded_words + CW'(1);
      end
      // Low cpu_active before the first high is the CPU coming out of reset, not a halt.
      if (state == RUN && cpu_active) seen_active <= 1'b1;
    end
  end

  instr_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .wr_en   (load_accept),
    .wr_addr (wr_ptr),
    .wr_data (load_data),
    .rd_addr (idx),
    .rd_data (rd_data)
  );

  // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
  assign off        = instr_address - BASE_ADDR;
  assign idx        = off[AW+1:2];
  assign in_range   = (off[31:AW+2] == '0);
  assign hit        = in_range && ({1'b0, idx} < loaded_words);
  assign unused_off = ^off[1:0];

  assign instr_readdata = hit ? rd_data : NOP_WORD;

`ifdef INSTR_MEM_FETCH_ERR_EN
  logic fetch_bad;

  assign fetch_bad = !hit || (instr_address[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_err      <= 1'b0;
      fetch_err_addr <= '0;
    end else if (state == RUN && cpu_clk_enable && fetch_bad && !fetch_err) begin
      fetch_err      <= 1'b1;
      fetch_err_addr <= instr_address;
    end
  end
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: load/run/halt sequencing, fetch gating and reset behaviour.
module tb_instr_mem_loader;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        cpu_reset;
  logic        cpu_clk_enable;
  logic        cpu_active;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [8:0]  loaded_words;
  logic [1:0]  run_state;
`ifdef INSTR_MEM_FETCH_ERR_EN
  logic        fetch_err;
  logic [31:0] fetch_err_addr;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_data      (load_data),
    .load_last      (load_last),
    .cpu_reset      (cpu_reset),
    .cpu_clk_enable (cpu_clk_enable),
    .cpu_active     (cpu_active),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .loaded_words   (loaded_words),
    .run_state      (run_state)
`ifdef INSTR_MEM_FETCH_ERR_EN
    ,
    .fetch_err      (fetch_err),
    .fetch_err_addr (fetch_err_addr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 32'hDEAD_BEEF;
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
    instr_address = a;
    #1;
    chk(tag, instr_readdata, exp);
  endtask

  initial begin
    reset         = 1'b1;
    load_valid    = 1'b0;
    load_data     = '0;
    load_last     = 1'b0;
    cpu_active    = 1'b0;
    instr_address = BASE;
    #3;
    chk("rst_state", 32'(run_state), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_clk_en", 32'(cpu_clk_enable), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_loaded", 32'(loaded_words), 32'd0);
`ifdef INSTR_MEM_FETCH_ERR_EN
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_fetch_err_addr", fetch_err_addr, 32'd0);
`endif
    step();
    reset = 1'b0;

    // Three-word program, idle gap carrying junk data in between.
    push(32'h2402_0005, 1'b0);
    step();
    chk("gap_ignored", 32'(loaded_words), 32'd1);
    push(32'h0000_0008, 1'b0);
    chk("mid_load_state", 32'(run_state), 32'd0);
    push(32'h0000_0000, 1'b1);
    chk("p3_state", 32'(run_state), 32'd1);
    chk("p3_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("p3_clk_en", 32'(cpu_clk_enable), 32'd1);
    chk("p3_load_ready", 32'(load_ready), 32'd0);
    chk("p3_loaded", 32'(loaded_words), 32'd3);

`ifdef INSTR_MEM_FETCH_ERR_EN
    instr_address = 32'hBFC0_0002;
    step();
    chk("ferr_set", 32'(fetch_err), 32'd1);
    chk("ferr_addr", fetch_err_addr, 32'hBFC0_0002);
    instr_address = 32'hBFC0_0004;
    step();
    chk("ferr_sticky", 32'(fetch_err), 32'd1);
    chk("ferr_addr_held", fetch_err_addr, 32'hBFC0_0002);
`endif

    fetch("p3_w0", 32'hBFC0_0000, 32'h2402_0005);
    fetch("p3_w0_lowbits", 32'hBFC0_0003, 32'h2402_0005);
    fetch("p3_w1", 32'hBFC0_0004, 32'h0000_0008);
    fetch("p3_w2", 32'hBFC0_0008, 32'h0000_0000);
    fetch("p3_unloaded", 32'hBFC0_000C, 32'h0000_0000);
    instr_address = BASE;

    // Low before the first high must not halt.
    cpu_active = 1'b0;
    repeat (3) step();
    chk("pre_active_run", 32'(run_state), 32'd1);
    cpu_active = 1'b1;
    repeat (5) step();
    chk("active_run", 32'(run_state), 32'd1);
    cpu_active = 1'b0;
    step();
    chk("halt_state", 32'(run_state), 32'd2);
    chk("halt_clk_en", 32'(cpu_clk_enable), 32'd0);
    chk("halt_cpu_reset", 32'(cpu_reset), 32'd0);
    cpu_active = 1'b1;
    step();
    chk("halt_terminal", 32'(run_state), 32'd2);
    cpu_active = 1'b0;

    // Asynchronous reset from HALTED.
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(run_state), 32'd0);
    chk("async_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("async_rst_loaded", 32'(loaded_words), 32'd0);
`ifdef INSTR_MEM_FETCH_ERR_EN
    chk("async_rst_ferr", 32'(fetch_err), 32'd0);
`endif
    step();
    reset = 1'b0;

    // Fill the whole array, no load_last, a gap after every 4th word.
    for (int i = 0; i < DEPTH; i++) begin
      push(32'hC0DE_0000 + 32'(i), 1'b0);
      if (i == 127) chk("fill_half", 32'(loaded_words), 32'd128);
      if (i % 4 == 3 && i != DEPTH - 1) step();
    end
    chk("fill_loaded", 32'(loaded_words), 32'(DEPTH));
    chk("fill_state", 32'(run_state), 32'd1);
    chk("fill_load_ready", 32'(load_ready), 32'd0);
    load_valid = 1'b1;
    load_data  = 32'h1234_5678;
    step();
    load_valid = 1'b0;
    chk("fill_no_extra", 32'(loaded_words), 32'(DEPTH));
    fetch("fill_first", BASE, 32'hC0DE_0000);
    fetch("fill_mid", BASE + 32'd400, 32'hC0DE_0064);
    fetch("fill_last", BASE + 32'(4 * (DEPTH - 1)), 32'hC0DE_00FF);
    fetch("oor_zero_addr", 32'h0000_0000, 32'h0000_0000);
    fetch("oor_past_end", BASE + 32'(4 * DEPTH), 32'h0000_0000);
    fetch("oor_below_base", BASE - 32'd4, 32'h0000_0000);
    instr_address = BASE;

    // Reset mid-load hides previously written words until reloaded.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    push(32'h1111_1111, 1'b0);
    push(32'h2222_2222, 1'b0);
    chk("partial_loaded", 32'(loaded_words), 32'd2);
    chk("partial_state", 32'(run_state), 32'd0);
    reset = 1'b1;
    #1;
    chk("midload_rst_loaded", 32'(loaded_words), 32'd0);
    fetch("midload_rst_w0", BASE, 32'h0000_0000);
    step();
    reset = 1'b0;
    push(32'h3333_3333, 1'b1);
    chk("reload_state", 32'(run_state), 32'd1);
    chk("reload_loaded", 32'(loaded_words), 32'd1);
    fetch("reload_w0", BASE, 32'h3333_3333);
    fetch("reload_w1_gated", BASE + 32'd4, 32'h0000_0000);
    instr_address = BASE;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Instruction-side memory for mips_cpu_harvard. Sits directly upstream of the CPU instruction port.
- After reset it fills its word array from a valid/ready load stream while holding the CPU in reset with its clock enable low.
- It then releases the CPU and serves instr_readdata combinationally from instr_address, as a single-cycle fetch.
- It stops the CPU clock enable once the CPU drops active.

Parameters:
- DEPTH, 256, number of 32-bit instruction words; power of two, at least 2.
- BASE_ADDR, 32'hBFC00000, byte address of word 0; equals the CPU reset vector.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_valid  in  1  load_data/load_last valid.
- load_ready  out  1  block can accept a load word.
- load_data  in  32  instruction word to store.
- load_last  in  1  marks the final program word.
- cpu_reset  out  1  drives CPU reset.
- cpu_clk_enable  out  1  drives CPU clk_enable.
- cpu_active  in  1  CPU active output.
- instr_address  in  32  CPU fetch byte address.
- instr_readdata  out  32  fetched word; combinational.
- loaded_words  out  $clog2(DEPTH)+1  count of words written.
- run_state  out  2  current FSM state: LOAD=0, RUN=1, HALTED=2.

Behaviour:
- Reset (asynchronous): state LOAD, wr_ptr=0, loaded_words=0, seen_active=0. Array contents are not cleared.
  - Reset values: cpu_reset=1, cpu_clk_enable=0, load_ready=1, run_state=0.
- LOAD state:
  - load_ready=1, cpu_reset=1, cpu_clk_enable=0.
  - A word is accepted on a rising edge with load_valid && load_ready: mem[wr_ptr]<=load_data, wr_ptr and loaded_words increment.
  - Go to RUN on the same edge that accepts a word with load_last=1, or the word that makes loaded_words==DEPTH.
  - No extra word is accepted after full; load_ready is 0 outside LOAD.
  - load_valid gaps are legal. load_data is ignored when not accepted.
- RUN state:
  - cpu_reset=0, cpu_clk_enable=1.
  - seen_active<=1 on any edge with cpu_active=1.
  - Go to HALTED on an edge where seen_active=1 and cpu_active=0. Low cpu_active before the first high is ignored, covering CPU reset recovery.
- HALTED state:
  - cpu_reset=0, cpu_clk_enable=0. Terminal until reset.
- Fetch (combinational, every state):
  - off = instr_address - BASE_ADDR (32-bit wrap); idx = off[31:2]. Low two address bits are ignored.
  - instr_readdata = mem[idx] if off < DEPTH*4 and idx < loaded_words; otherwise 32'h00000000 (NOP).
  - Addresses below BASE_ADDR wrap to large off and return 0.
- Reset mid-load: pointer and count return to 0. Previously written words read as 0 until reloaded, because of the idx<loaded_words gate.
- Reset in RUN or HALTED: back to LOAD and cpu_reset reasserted asynchronously.
- Empty program is not possible: at least one word, the load_last word, is always loaded.

Optional Feature:
- Macro INSTR_MEM_FETCH_ERR_EN.
- When defined:
  - Adds output fetch_err (1 bit) and fetch_err_addr (32 bits).
  - In RUN, on the first rising edge where cpu_clk_enable=1 and the fetch is out of range, misaligned (instr_address[1:0]!=0), or idx>=loaded_words:
    - fetch_err latches 1 (sticky until reset).
    - fetch_err_addr latches instr_address.
  - Reset values: 0.
- When undefined: ports absent, no error logic.

Decomposition:
- Package mips_mem_pkg holds:
  - RESET_VECTOR = 32'hBFC00000.
  - The NOP word constant.
  - typedef enum logic[1:0] {LOAD, RUN, HALTED} loader_state_t.
- One natural sub-module: instr_mem_array, a DEPTH x 32 array with synchronous write and asynchronous read.
- FSM, counters and address decode live in instr_mem_loader.

Test Plan:
- Load 3 words 0x24020005, 0x00000008, 0x00000000 with load_last on the third → RUN on that edge, cpu_reset=0, cpu_clk_enable=1. Fetch 0xBFC00000 → 0x24020005; 0xBFC00008 → 0; 0xBFC0000C → 0 (unloaded).
- Stream DEPTH words with no load_last and a one-cycle valid gap every 4th word → loaded_words=DEPTH, RUN, load_ready=0; last address BFC00000+4*(DEPTH-1) returns the final word.
- In RUN, fetch 0x00000000 and 0xBFC00000+4*DEPTH → 0.
- RUN with cpu_active held 0 for 3 cycles then 1 for 5 cycles then 0 → stays RUN until the falling edge, then HALTED with cpu_clk_enable=0.
- Load 2 of 5 words, pulse reset → loaded_words=0, fetch 0xBFC00000 → 0. Reload 1 word with load_last → reads the new word.
- With INSTR_MEM_FETCH_ERR_EN: in RUN, fetch 0xBFC00002 → fetch_err=1, fetch_err_addr=0xBFC00002. A later valid fetch leaves both unchanged.
